// File: rtl/popcount_window_accumulator.sv
// Sums 3-bit popcount beats over a window of up to BEATS beats (or until in_last) and
// holds the total, beat count and threshold hit until accepted. Optional: POPACC_SATURATE_EN.
module popcount_window_accumulator #(
   parameter int IN_W  = 3,
   parameter int BEATS = 16,
   parameter int ACC_W = 7,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   input  logic             in_last,
   input  logic [ACC_W-1:0] threshold,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic [CNT_W-1:0] out_beats,
`ifdef POPACC_SATURATE_EN
   output logic             out_ovf,
`endif
   output logic             out_hit
);

   typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [ACC_W-1:0] out_sum_q, out_sum_d;
   logic [CNT_W-1:0] out_beats_q, out_beats_d;
   logic             out_hit_q, out_hit_d;
   logic [ACC_W-1:0] sum_v;
   logic             accept;
   logic             close;

`ifdef POPACC_SATURATE_EN
   logic [ACC_W:0]   sum_full;
   logic             sat;
   logic             win_ovf_q, win_ovf_d;
   logic             out_ovf_q, out_ovf_d;

   // One extra bit of headroom detects the carry out that triggers saturation.
   assign sum_full = (ACC_W+1)'(acc_q) + (ACC_W+1)'(in_data);
   assign sat      = sum_full[ACC_W];
   assign sum_v    = sat ? {ACC_W{1'b1}} : sum_full[ACC_W-1:0];
   assign out_ovf  = out_ovf_q;
`else
   assign sum_v = acc_q + ACC_W'(in_data);
`endif

   assign in_ready  = (state_q == ACCUM);
   assign out_valid = (state_q == HOLD);
   assign out_sum   = out_sum_q;
   assign out_beats = out_beats_q;
   assign out_hit   = out_hit_q;

   assign accept = in_valid && (state_q == ACCUM);
   assign close  = accept && (in_last || (cnt_q == CNT_W'(BEATS - 1)));

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      out_sum_d   = out_sum_q;
      out_beats_d = out_beats_q;
      out_hit_d   = out_hit_q;
`ifdef POPACC_SATURATE_EN
      win_ovf_d   = win_ovf_q;
      out_ovf_d   = out_ovf_q;
`endif
      if (clear) begin
         // Abort wins over any beat or result handshake in this cycle.
         state_d = ACCUM;
         acc_d   = '0;
         cnt_d   = '0;
`ifdef POPACC_SATURATE_EN
         win_ovf_d = 1'b0;
`endif
      end else begin
         case (state_q)
            ACCUM: begin
               if (close) begin
                  out_sum_d   = sum_v;
                  out_beats_d = cnt_q + CNT_W'(1);
                  out_hit_d   = (sum_v >= threshold);
                  acc_d       = '0;
                  cnt_d       = '0;
                  state_d     = HOLD;
`ifdef POPACC_SATURATE_EN
                  out_ovf_d   = win_ovf_q | sat;
                  win_ovf_d   = 1'b0;
`endif
               end else if (accept) begin
                  acc_d = sum_v;
                  cnt_d = cnt_q + CNT_W'(1);
`ifdef POPACC_SATURATE_EN
                  win_ovf_d = win_ovf_q | sat;
`endif
               end
            end
            HOLD: begin
               if (out_ready) state_d = ACCUM;
            end
            default: state_d = ACCUM;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ACCUM;
         acc_q       <= '0;
         cnt_q       <= '0;
         out_sum_q   <= '0;
         out_beats_q <= '0;
         out_hit_q   <= 1'b0;
`ifdef POPACC_SATURATE_EN
         win_ovf_q   <= 1'b0;
         out_ovf_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         out_sum_q   <= out_sum_d;
         out_beats_q <= out_beats_d;
         out_hit_q   <= out_hit_d;
`ifdef POPACC_SATURATE_EN
         win_ovf_q   <= win_ovf_d;
         out_ovf_q   <= out_ovf_d;
`endif
      end
   end

endmodule

// File: tb/tb_popcount_window_accumulator.sv
// Directed self-checking bench for popcount_window_accumulator (default build plus an ACC_W=6 instance).
module tb_popcount_window_accumulator;

   logic       clk = 1'b0;
   logic       rst_n, clear, in_valid, in_last, out_ready;
   logic [2:0] in_data;
   logic [6:0] threshold;
   logic       in_ready, out_valid, out_hit;
   logic [6:0] out_sum;
   logic [4:0] out_beats;
   logic       in_ready6, out_valid6, out_hit6;
   logic [5:0] out_sum6, threshold6;
   logic [4:0] out_beats6;
`ifdef POPACC_SATURATE_EN
   logic       out_ovf, out_ovf6;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;
   assign threshold6 = threshold[5:0];

   popcount_window_accumulator dut (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_last(in_last), .threshold(threshold), .out_valid(out_valid),
      .out_ready(out_ready), .out_sum(out_sum), .out_beats(out_beats),
`ifdef POPACC_SATURATE_EN
      .out_ovf(out_ovf),
`endif
      .out_hit(out_hit)
   );

   popcount_window_accumulator #(.ACC_W(6)) dut6 (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready6),
      .in_data(in_data), .in_last(in_last), .threshold(threshold6), .out_valid(out_valid6),
      .out_ready(out_ready), .out_sum(out_sum6), .out_beats(out_beats6),
`ifdef POPACC_SATURATE_EN
      .out_ovf(out_ovf6),
`endif
      .out_hit(out_hit6)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [2:0] d, input logic last);
      in_valid = 1'b1; in_data = d; in_last = last;
      step();
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
      out_ready = 1'b0; threshold = '0;
      step(); step();
      rst_n = 1'b1;
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
      tests++; if (out_sum !== 7'd0) begin fails++; $display("FAIL reset_out_sum got %0d exp 0", out_sum); end
      tests++; if (out_beats !== 5'd0) begin fails++; $display("FAIL reset_out_beats got %0d exp 0", out_beats); end
      tests++; if (out_hit !== 1'b0) begin fails++; $display("FAIL reset_out_hit got %b exp 0", out_hit); end
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
      $display("[TB] reset done");
   endtask

   task automatic test_full_window();
      out_ready = 1'b1; threshold = 7'd100;
      for (int i = 0; i < 16; i++) begin
         in_valid = 1'b1; in_data = 3'd7; in_last = 1'b0;
         tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL full_early_valid beat %0d got %b exp 0", i, out_valid); end
         step();
      end
      in_valid = 1'b0;
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL full_out_valid got %b exp 1", out_valid); end
      tests++; if (out_sum !== 7'd112) begin fails++; $display("FAIL full_out_sum got %0d exp 112", out_sum); end
      tests++; if (out_beats !== 5'd16) begin fails++; $display("FAIL full_out_beats got %0d exp 16", out_beats); end
      tests++; if (out_hit !== 1'b1) begin fails++; $display("FAIL full_out_hit got %b exp 1", out_hit); end
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL full_in_ready_low got %b exp 0", in_ready); end
`ifdef POPACC_SATURATE_EN
      tests++; if (out_sum6 !== 6'd63) begin fails++; $display("FAIL acc6_out_sum got %0d exp 63", out_sum6); end
      tests++; if (out_ovf6 !== 1'b1) begin fails++; $display("FAIL acc6_out_ovf got %b exp 1", out_ovf6); end
      tests++; if (out_ovf !== 1'b0) begin fails++; $display("FAIL acc7_out_ovf got %b exp 0", out_ovf); end
`else
      tests++; if (out_sum6 !== 6'd48) begin fails++; $display("FAIL acc6_out_sum got %0d exp 48", out_sum6); end
`endif
      tests++; if (out_beats6 !== 5'd16) begin fails++; $display("FAIL acc6_out_beats got %0d exp 16", out_beats6); end
      // threshold6 = 100 mod 64 = 36; both 48 and 63 reach it
      tests++; if (out_hit6 !== 1'b1) begin fails++; $display("FAIL acc6_out_hit got %b exp 1", out_hit6); end
      step();
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL full_in_ready_back got %b exp 1", in_ready); end
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL full_out_valid_drop got %b exp 0", out_valid); end
      $display("[TB] full window 16x7 sum=%0d beats=%0d hit=%b", 112, 16, 1);
   endtask

   task automatic test_early_last();
      logic [6:0] thr [2];
      logic       exp_hit [2];
      thr[0] = 7'd10; thr[1] = 7'd11; exp_hit[0] = 1'b1; exp_hit[1] = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 2; k++) begin
         threshold = thr[k];
         beat(3'd3, 1'b0); beat(3'd5, 1'b0); beat(3'd2, 1'b1);
         tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL last_out_valid thr %0d got %b exp 1", thr[k], out_valid); end
         tests++; if (out_sum !== 7'd10) begin fails++; $display("FAIL last_out_sum thr %0d got %0d exp 10", thr[k], out_sum); end
         tests++; if (out_beats !== 5'd3) begin fails++; $display("FAIL last_out_beats thr %0d got %0d exp 3", thr[k], out_beats); end
         tests++; if (out_hit !== exp_hit[k]) begin fails++; $display("FAIL last_out_hit thr %0d got %b exp %b", thr[k], out_hit, exp_hit[k]); end
         step();
         $display("[TB] early last thr=%0d sum=10 beats=3", thr[k]);
      end
   endtask

   task automatic test_back_to_back_hold();
      out_ready = 1'b0; threshold = 7'd0;
      beat(3'd1, 1'b0); beat(3'd1, 1'b1);
      in_valid = 1'b1; in_data = 3'd7;
      for (int i = 0; i < 5; i++) begin
         tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL hold_in_ready cyc %0d got %b exp 0", i, in_ready); end
         tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL hold_out_valid cyc %0d got %b exp 1", i, out_valid); end
         tests++; if (out_sum !== 7'd2 || out_beats !== 5'd2) begin fails++; $display("FAIL hold_stable cyc %0d got sum %0d beats %0d exp 2 2", i, out_sum, out_beats); end
         step();
      end
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL hold_release got %b exp 1", in_ready); end
      beat(3'd4, 1'b1);
      tests++; if (out_sum !== 7'd4 || out_beats !== 5'd1) begin fails++; $display("FAIL hold_next_window got sum %0d beats %0d exp 4 1", out_sum, out_beats); end
      step();
      $display("[TB] hold 5 cycles then next window sum=4 beats=1");
   endtask

   task automatic test_idle_gaps();
      out_ready = 1'b1; threshold = 7'd16;
      for (int i = 0; i < 16; i++) begin
         if ($urandom_range(0, 1) == 1) step();
         if (i == 15) begin
            tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL gaps_early_valid got %b exp 0", out_valid); end
         end
         beat(3'd1, (i == 15));
      end
      tests++; if (out_sum !== 7'd16) begin fails++; $display("FAIL gaps_out_sum got %0d exp 16", out_sum); end
      tests++; if (out_beats !== 5'd16) begin fails++; $display("FAIL gaps_out_beats got %0d exp 16", out_beats); end
      tests++; if (out_hit !== 1'b1) begin fails++; $display("FAIL gaps_out_hit got %b exp 1", out_hit); end
      step(); step();
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL gaps_double_close got %b exp 0", out_valid); end
      $display("[TB] idle gaps 16x1 sum=16 beats=16");
   endtask

   task automatic test_clear();
      out_ready = 1'b1; threshold = 7'd0;
      for (int i = 0; i < 8; i++) beat(3'd4, 1'b0);
      clear = 1'b1; in_valid = 1'b1; in_data = 3'd4;
      step();
      clear = 1'b0; in_valid = 1'b0;
      beat(3'd6, 1'b0); beat(3'd6, 1'b1);
      tests++; if (out_sum !== 7'd12) begin fails++; $display("FAIL clear_out_sum got %0d exp 12", out_sum); end
      tests++; if (out_beats !== 5'd2) begin fails++; $display("FAIL clear_out_beats got %0d exp 2", out_beats); end
      out_ready = 1'b0;
      clear = 1'b1;
      step();
      clear = 1'b0;
      tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL clear_hold got valid %b ready %b exp 0 1", out_valid, in_ready); end
      out_ready = 1'b1;
      $display("[TB] clear mid-window and mid-hold");
   endtask

   task automatic test_reset_mid_window();
      beat(3'd5, 1'b0); beat(3'd5, 1'b0); beat(3'd5, 1'b0);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      tests++; if (out_sum !== 7'd0 || out_valid !== 1'b0) begin fails++; $display("FAIL rst_mid got sum %0d valid %b exp 0 0", out_sum, out_valid); end
      beat(3'd2, 1'b1);
      tests++; if (out_sum !== 7'd2 || out_beats !== 5'd1) begin fails++; $display("FAIL rst_mid_next got sum %0d beats %0d exp 2 1", out_sum, out_beats); end
      step();
      $display("[TB] reset mid-window");
   endtask

   initial begin
      test_reset();
      test_full_window();
      test_early_last();
      test_back_to_back_hold();
      test_idle_gaps();
      test_clear();
      test_reset_mid_window();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/popcount_window_accumulator.md
Name: popcount_window_accumulator

Overview:
- Sequential stage directly downstream of the 7-input popcount adder.
- Consumes its 3-bit count (0..7) per beat over a valid/ready stream and sums counts across a window of BEATS beats, or fewer if closed early by in_last.
- Presents the window total, the beat count and a threshold-compare bit on a valid/ready output held until accepted; feeds the classification/decision logic.

Parameters:
- IN_W, 3, width of incoming popcount value (max value 2^IN_W-1 = 7).
- BEATS, 16, maximum beats per window; the window closes automatically on beat BEATS.
- ACC_W, 7, accumulator/result width; default holds 16*7 = 112 without overflow.
- CNT_W, 5, beat-counter width; must satisfy 2^CNT_W > BEATS.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- clear  in  1  synchronous abort: drop the partial window and any held result.
- in_valid  in  1  popcount beat valid.
- in_ready  out  1  stage can accept a beat.
- in_data  in  IN_W  popcount value from the adder.
- in_last  in  1  beat closes the window early.
- threshold  in  ACC_W  compare level, sampled on the closing beat.
- out_valid  out  1  result valid, held until out_ready.
- out_ready  in  1  downstream accepts result.
- out_sum  out  ACC_W  window total.
- out_beats  out  CNT_W  beats in window (1..BEATS).
- out_hit  out  1  out_sum >= threshold (unsigned).

Behaviour:
- Reset (rst_n=0 at clk edge):
  - state=ACCUM; acc=0; cnt=0.
  - out_valid=0, out_sum=0, out_beats=0, out_hit=0.
  - in_ready=1 in the first cycle after reset is released.
- States:
  - ACCUM: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- ACCUM, accepted beat (in_valid & in_ready):
  - acc += zero-extended in_data; cnt += 1.
- Closing beat (in_last=1 or cnt==BEATS-1), registered at the same edge:
  - out_sum = acc + in_data.
  - out_beats = cnt + 1.
  - out_hit = (acc + in_data) >= threshold.
  - acc and cnt cleared to 0; state goes to HOLD.
- Latency: out_valid rises the cycle after the closing beat is accepted.
- HOLD:
  - out_sum, out_beats and out_hit are stable.
  - On out_valid & out_ready: state goes to ACCUM, and in_ready is 1 the next cycle.
  - One bubble cycle per window; no result overlap.
- Idle: in_valid=0 leaves acc and cnt unchanged (the window may span idle cycles).
- Zero-valued beats count toward cnt and BEATS.
- in_last together with cnt==BEATS-1: a single close, out_beats=BEATS.
- clear=1 (priority below rst_n, above everything else):
  - acc=0, cnt=0, out_valid=0, state goes to ACCUM.
  - A beat or result handshake in the same cycle is discarded.
  - Output data registers keep their old values (don't-care while out_valid=0).
- Reset mid-window or mid-HOLD: identical to power-on reset; the partial sum is lost.
- Overflow (only if ACC_W is undersized): the sum wraps modulo 2^ACC_W unless the optional feature is enabled.

Optional Feature:
- Macro: POPACC_SATURATE_EN.
- Defined:
  - acc and the closing sum saturate at 2^ACC_W-1.
  - Extra output out_ovf (1 bit): set when any add in the window saturated; registered with out_sum; reset and clear value 0.
- Undefined: modulo wrap; port out_ovf absent.

Test Plan:
- Reset, then 16 beats of in_data=7, out_ready=1, threshold=100 -> out_valid one cycle after beat 16; out_sum=112, out_beats=16, out_hit=1; in_ready low exactly one cycle.
- Beats 3,5,2 with in_last on 2, threshold=10 -> out_sum=10, out_beats=3, out_hit=1; with threshold=11 -> out_hit=0.
- Close a window with out_ready=0 for 5 cycles and in_valid held 1 -> in_ready=0 and out_* stable throughout; after out_ready=1, the next window starts with acc=0.
- Random in_valid gaps (50%) over 16 beats of value 1 -> out_sum=16, out_beats=16; idle cycles do not change the count.
- 8 beats of 4, then clear=1 with in_valid=1, then 2 beats of 6 with in_last -> out_sum=12, out_beats=2; the cleared beat is not counted.
- POPACC_SATURATE_EN with ACC_W=6: 16 beats of 7 -> out_sum=63, out_ovf=1; without the macro -> out_sum=48 (112 mod 64).
